// File: rtl/mvau_inp_stream_buffer.sv
// Input-activation buffer for the MVAU: forwards one SF-word vector as it arrives,
// then replays the stored copy for each of the remaining NF-1 row-folds.
module mvau_inp_stream_buffer #(
  parameter int unsigned TI      = 16,
  parameter int unsigned MatrixW = 20,
  parameter int unsigned SIMD    = 2,
  parameter int unsigned MatrixH = 20,
  parameter int unsigned PE      = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_v,
  output logic          in_rdy,
  input  logic [TI-1:0] in_data,
  output logic          out_v,
  input  logic          out_rdy,
  output logic [TI-1:0] out_data,
  output logic          out_sf_last,
  output logic          out_nf_last
);

  localparam int unsigned SF   = MatrixW / SIMD;
  localparam int unsigned NF   = MatrixH / PE;
  localparam int unsigned SF_W = (SF > 1) ? $clog2(SF) : 1;
  localparam int unsigned NF_W = (NF > 1) ? $clog2(NF) : 1;
  localparam logic        NF_ONE = (NF == 1);

  localparam logic [0:0] ST_FILL   = 1'b0;
  localparam logic [0:0] ST_REPLAY = 1'b1;

  logic [0:0]    state_r;
  logic [SF_W-1:0] sf_r;
  logic [NF_W-1:0] nf_r;
  logic [TI-1:0] mem_r [SF];

  logic adv_s;
  logic in_fire_s;
  logic sf_last_s;
  logic nf_last_s;

  assign adv_s     = !out_v || out_rdy;
  assign in_fire_s = in_v && in_rdy;
  assign sf_last_s = (sf_r == SF_W'(SF - 1));
  assign nf_last_s = (nf_r == NF_W'(NF - 1));

  // Input is only accepted while filling, and only when the output slot can move.
  always_comb begin
    in_rdy = 1'b0;
    if (state_r == ST_FILL) begin
      in_rdy = adv_s;
    end else begin
      in_rdy = 1'b0;
    end
  end

  // Vector storage; contents survive reset since every vector is rewritten before replay.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      mem_r[sf_r] <= in_data;
    end
  end

  // Fold sequencing and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_FILL;
      sf_r        <= {SF_W{1'b0}};
      nf_r        <= {NF_W{1'b0}};
      out_v       <= 1'b0;
      out_data    <= {TI{1'b0}};
      out_sf_last <= 1'b0;
      out_nf_last <= 1'b0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (adv_s) begin
            if (in_v) begin
              out_data    <= in_data;
              out_v       <= 1'b1;
              out_sf_last <= sf_last_s;
              out_nf_last <= NF_ONE;
              if (sf_last_s) begin
                sf_r <= {SF_W{1'b0}};
                if (NF_ONE) begin
                  nf_r    <= {NF_W{1'b0}};
                  state_r <= ST_FILL;
                end else begin
                  nf_r    <= NF_W'(1);
                  state_r <= ST_REPLAY;
                end
              end else begin
                sf_r <= sf_r + SF_W'(1);
              end
            end else begin
              out_v <= 1'b0;
            end
          end
        end
        ST_REPLAY: begin
          if (adv_s) begin
            out_data    <= mem_r[sf_r];
            out_v       <= 1'b1;
            out_sf_last <= sf_last_s;
            out_nf_last <= nf_last_s;
            if (sf_last_s) begin
              sf_r <= {SF_W{1'b0}};
              if (nf_last_s) begin
                nf_r    <= {NF_W{1'b0}};
                state_r <= ST_FILL;
              end else begin
                nf_r <= nf_r + NF_W'(1);
              end
            end else begin
              sf_r <= sf_r + SF_W'(1);
            end
          end
        end
        default: begin
          state_r <= ST_FILL;
          sf_r    <= {SF_W{1'b0}};
          nf_r    <= {NF_W{1'b0}};
          out_v   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvau_inp_stream_buffer.sv
// Directed bench for mvau_inp_stream_buffer with SF=4, NF=3: table rows of
// {inputs, expected in_rdy before the edge, expected outputs after the edge}.
module tb_mvau_inp_stream_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_v;
  logic        in_rdy;
  logic [15:0] in_data;
  logic        out_v;
  logic        out_rdy;
  logic [15:0] out_data;
  logic        out_sf_last;
  logic        out_nf_last;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [15:0] A = 16'hA000;
  localparam logic [15:0] B = 16'hB000;
  localparam logic [15:0] C = 16'hC000;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        ei;
    logic        ev;
    logic [15:0] ed;
    logic        es;
    logic        en;
  } row_t;

  row_t tbl[$];

  mvau_inp_stream_buffer #(
    .TI(16), .MatrixW(8), .SIMD(2), .MatrixH(6), .PE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_v(in_v), .in_rdy(in_rdy), .in_data(in_data),
    .out_v(out_v), .out_rdy(out_rdy), .out_data(out_data),
    .out_sf_last(out_sf_last), .out_nf_last(out_nf_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] wd(input logic [15:0] base, input int i);
    return base + 16'(i);
  endfunction

  function automatic row_t mk(input logic v, input logic [15:0] d, input logic r,
                              input logic ei, input logic ev, input logic [15:0] ed,
                              input logic es, input logic en);
    row_t x;
    x.v = v; x.d = d; x.r = r; x.ei = ei;
    x.ev = ev; x.ed = ed; x.es = es; x.en = en;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_tbl(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      in_v    = tbl[i].v;
      in_data = tbl[i].d;
      out_rdy = tbl[i].r;
      #1;
      chk($sformatf("%s[%0d].in_rdy", nm, i), {31'd0, in_rdy}, {31'd0, tbl[i].ei});
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].out_v", nm, i), {31'd0, out_v}, {31'd0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("%s[%0d].out_data", nm, i), {16'd0, out_data}, {16'd0, tbl[i].ed});
        chk($sformatf("%s[%0d].sf_last", nm, i), {31'd0, out_sf_last}, {31'd0, tbl[i].es});
        chk($sformatf("%s[%0d].nf_last", nm, i), {31'd0, out_nf_last}, {31'd0, tbl[i].en});
      end
    end
    tbl.delete();
  endtask

  initial begin
    rst_n   = 1'b0;
    in_v    = 1'b0;
    in_data = 16'h0000;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset.out_v", {31'd0, out_v}, 32'd0);
    chk("reset.in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("reset.out_data", {16'd0, out_data}, 32'd0);
    chk("reset.sf_last", {31'd0, out_sf_last}, 32'd0);
    chk("reset.nf_last", {31'd0, out_nf_last}, 32'd0);

    // Single vector streamed then replayed twice, out_rdy held high.
    for (int k = 0; k < 12; k++)
      tbl.push_back(mk(k < 4, (k < 4) ? wd(A, k) : 16'h0000, 1'b1, k < 4,
                       1'b1, wd(A, k % 4), (k % 4) == 3, k >= 8));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
    run_tbl("stream");

    // Vector B presented during A's replay; B0 must go in right after the last A word.
    for (int k = 0; k < 24; k++) begin
      int j;
      logic [15:0] base;
      logic [15:0] d;
      j    = k % 12;
      base = (k < 12) ? A : B;
      if (k < 4)       d = wd(A, k);
      else if (k < 12) d = wd(B, 0);
      else if (k < 16) d = wd(B, k - 12);
      else             d = 16'h0000;
      tbl.push_back(mk(k < 16, d, 1'b1, (k < 4) || (k >= 12 && k < 16),
                       1'b1, wd(base, j % 4), (j % 4) == 3, j >= 8));
    end
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
    run_tbl("b2b");

    // Backpressure: once during fill, then three cycles on replayed A1.
    tbl.push_back(mk(1'b1, wd(A, 0), 1'b1, 1'b1, 1'b1, wd(A, 0), 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, wd(A, 1), 1'b0, 1'b0, 1'b1, wd(A, 0), 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, wd(A, 1), 1'b1, 1'b1, 1'b1, wd(A, 1), 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, wd(A, 2), 1'b1, 1'b1, 1'b1, wd(A, 2), 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, wd(A, 3), 1'b1, 1'b1, 1'b1, wd(A, 3), 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, wd(A, 0), 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, wd(A, 1), 1'b0, 1'b0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, wd(A, 1), 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, wd(A, 2), 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, wd(A, 3), 1'b1, 1'b0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, wd(A, k), k == 3, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
    run_tbl("hold");

    // Input gaps during fill give bubbles; replay follows only the last word.
    tbl.push_back(mk(1'b1, wd(A, 0), 1'b1, 1'b1, 1'b1, wd(A, 0), 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, wd(A, 1), 1'b1, 1'b1, 1'b1, wd(A, 1), 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, wd(A, 2), 1'b1, 1'b1, 1'b1, wd(A, 2), 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, wd(A, 3), 1'b1, 1'b1, 1'b1, wd(A, 3), 1'b1, 1'b0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, wd(A, k % 4), (k % 4) == 3, k >= 4));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
    run_tbl("gaps");

    // Reset pulse in the middle of fold 1, then a fresh vector C.
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(k < 4, (k < 4) ? wd(A, k) : 16'h0000, 1'b1, k < 4,
                       1'b1, wd(A, k % 4), (k % 4) == 3, 1'b0));
    run_tbl("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_v", {31'd0, out_v}, 32'd0);
    chk("midrst.out_data", {16'd0, out_data}, 32'd0);
    chk("midrst.sf_last", {31'd0, out_sf_last}, 32'd0);
    chk("midrst.nf_last", {31'd0, out_nf_last}, 32'd0);
    chk("midrst.in_rdy", {31'd0, in_rdy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++)
      tbl.push_back(mk(k < 4, (k < 4) ? wd(C, k) : 16'h0000, 1'b1, k < 4,
                       1'b1, wd(C, k % 4), (k % 4) == 3, k >= 8));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
    run_tbl("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
